hammer_campaign_ctrl: RTL and testbench

- Sequences repeated runs of the single-row hammer test engine across a contiguous range of victim rows.
- Per row: sets up the engine's address, pattern and count; restarts the engine through its reset; waits for the engine FINISH state; collects the bit-flip count.
- Keeps a campaign total and logs every row with nonzero flips into a small result FIFO drained by the host register block.

---
 rtl/hammer_campaign_ctrl_if.sv | 32 +++
 rtl/hammer_campaign_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_hammer_campaign_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hammer_campaign_ctrl_if.sv
// Engine control bus and result-log handshake of the hammer campaign controller.
interface hammer_campaign_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int ROW_WIDTH  = 12
);
  logic                  eng_reset;
  logic [ADDR_WIDTH-1:0] eng_address;
  logic [WORD_WIDTH-1:0] eng_pattern;
  logic [31:0]           eng_count;
  logic [3:0]            eng_state;
  logic [63:0]           eng_flips;
  logic                  log_valid;
  logic [ROW_WIDTH-1:0]  log_row;
  logic [31:0]           log_flips;
  logic                  log_ready;
  logic                  log_overflow;

  modport master (
    output eng_reset, eng_address, eng_pattern, eng_count,
    input  eng_state, eng_flips,
    output log_valid, log_row, log_flips, log_overflow,
    input  log_ready
  );

  modport slave (
    input  eng_reset, eng_address, eng_pattern, eng_count,
    output eng_state, eng_flips,
    input  log_valid, log_row, log_flips, log_overflow,
    output log_ready
  );
endinterface

// File: rtl/hammer_campaign_ctrl.sv
// Row-sweep sequencer for the hammer engine with flip totals and a result log.
// Optional PATTERN_INVERT_EN: two passes per row (pattern, then ~pattern).
module hammer_campaign_ctrl #(
  parameter int          ADDR_WIDTH     = 64,
  parameter int          WORD_WIDTH     = 64,
  parameter int          ROW_WIDTH      = 12,
  parameter int          ROW_POS        = 10,
  parameter int          LOG_DEPTH      = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0100_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ROW_WIDTH-1:0]  row_count,
  input  logic [31:0]           hammer_count,
  input  logic [WORD_WIDTH-1:0] pattern,
  hammer_campaign_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  timeout_err,
  output logic [ROW_WIDTH-1:0]  rows_done,
  output logic [63:0]           total_flips
);

  localparam int EW = ROW_WIDTH + 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_COLLECT, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ROW_WIDTH-1:0]  r_rows;
  logic [31:0]           r_hcount;
  logic [WORD_WIDTH-1:0] r_pattern;
  logic                  r_eng_reset;
  logic [ADDR_WIDTH-1:0] r_eng_addr;
  logic [31:0]           r_wd;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_timeout;
  logic [ROW_WIDTH-1:0]  r_rows_done;
  logic [63:0]           r_total;
  logic                  r_overflow;
  logic [LOG_DEPTH:0]    r_wr_ptr;
  logic [LOG_DEPTH:0]    r_rd_ptr;
  logic [EW-1:0]         r_mem [2**LOG_DEPTH];

  logic                  w_idle;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_log_now;
  logic [63:0]           w_sum;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_drop;
  logic [ROW_WIDTH-1:0]  w_rows_nxt;
  logic [EW-1:0]         w_head;

  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? '1 : s[63:0];
  endfunction

  function automatic logic [31:0] sat32(input logic [63:0] f);
    return (|f[63:32]) ? 32'hFFFF_FFFF : f[31:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] row_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ROW_WIDTH-1:0]  off
  );
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    r[ROW_POS +: ROW_WIDTH] = a[ROW_POS +: ROW_WIDTH] + off;
    return r;
  endfunction

`ifdef PATTERN_INVERT_EN
  logic        r_pass;
  logic [63:0] r_acc;
  assign w_sum           = sat_add(r_acc, bus.eng_flips);
  assign w_log_now       = r_pass;
  assign bus.eng_pattern = r_pass ? ~r_pattern : r_pattern;
`else
  assign w_sum           = bus.eng_flips;
  assign w_log_now       = 1'b1;
  assign bus.eng_pattern = r_pattern;
`endif

  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                      (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);
  assign w_pop      = !w_empty && bus.log_ready;
  assign w_push_req = (r_state == S_COLLECT) && !abort &&
                      w_log_now && (w_sum != 64'd0);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;
  assign w_rows_nxt = r_rows_done + ROW_WIDTH'(1);
  assign w_head     = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= {r_rows_done, sat32(w_sum)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_rows      <= '0;
      r_hcount    <= '0;
      r_pattern   <= '0;
      r_eng_reset <= 1'b1;
      r_eng_addr  <= '0;
      r_wd        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_timeout   <= 1'b0;
      r_rows_done <= '0;
      r_total     <= '0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifdef PATTERN_INVERT_EN
      r_pass      <= 1'b0;
      r_acc       <= '0;
`endif
    end else begin
      if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_idle) begin
        if (start) begin
          r_base      <= base_address;
          r_rows      <= row_count;
          r_hcount    <= hammer_count;
          r_pattern   <= pattern;
          r_eng_addr  <= row_addr(base_address, '0);
          r_rows_done <= '0;
          r_total     <= '0;
          r_aborted   <= 1'b0;
          r_timeout   <= 1'b0;
          r_overflow  <= 1'b0;
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
`ifdef PATTERN_INVERT_EN
          r_pass      <= 1'b0;
`endif
          r_busy      <= (row_count != '0);
          r_done      <= (row_count == '0);
          r_state     <= (row_count == '0) ? S_DONE : S_LAUNCH;
        end
      end else if (abort) begin
        r_state     <= S_DONE;
        r_aborted   <= 1'b1;
        r_eng_reset <= 1'b1;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end else begin
        unique case (r_state)
          S_LAUNCH: begin
            r_eng_reset <= 1'b0;
            r_wd        <= '0;
            r_state     <= S_RUN;
          end
          S_RUN: begin
            if (bus.eng_state == 4'd4) begin
              r_eng_reset <= 1'b1;
              r_state     <= S_COLLECT;
            end else if (r_wd == TIMEOUT_CYCLES - 32'd1) begin
              r_eng_reset <= 1'b1;
              r_timeout   <= 1'b1;
              r_state     <= S_NEXT;
            end else begin
              r_wd <= r_wd + 32'd1;
            end
          end
          S_COLLECT: begin
            r_total <= sat_add(r_total, bus.eng_flips);
`ifdef PATTERN_INVERT_EN
            if (!r_pass) begin
              r_acc   <= bus.eng_flips;
              r_pass  <= 1'b1;
              r_state <= S_LAUNCH;
            end else begin
              r_state <= S_NEXT;
            end
`else
            r_state <= S_NEXT;
`endif
          end
          S_NEXT: begin
            r_rows_done <= w_rows_nxt;
`ifdef PATTERN_INVERT_EN
            r_pass      <= 1'b0;
`endif
            if (w_rows_nxt == r_rows) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_eng_addr <= row_addr(r_base, w_rows_nxt);
              r_state    <= S_LAUNCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.eng_reset    = r_eng_reset;
  assign bus.eng_address  = r_eng_addr;
  assign bus.eng_count    = r_hcount;
  assign bus.log_valid    = !w_empty;
  assign bus.log_row      = w_empty ? '0 : w_head[EW-1:32];
  assign bus.log_flips    = w_empty ? '0 : w_head[31:0];
  assign bus.log_overflow = r_overflow;

  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign timeout_err = r_timeout;
  assign rows_done   = r_rows_done;
  assign total_flips = r_total;

endmodule

// File: tb/tb_hammer_campaign_ctrl.sv
// Directed bench for hammer_campaign_ctrl with a small behavioural engine model.
module tb_hammer_campaign_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [63:0] base_address;
  logic [11:0] row_count;
  logic [31:0] hammer_count;
  logic [63:0] pattern;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        timeout_err;
  logic [11:0] rows_done;
  logic [63:0] total_flips;

  int checks = 0;
  int errors = 0;

  logic [63:0] flip_tab [0:4095];
  logic [63:0] launch_q [$];
  logic [7:0]  eng_cyc;
  logic        eng_hang;
  logic        prev_rst;

  hammer_campaign_ctrl_if #(
    .ADDR_WIDTH(64), .WORD_WIDTH(64), .ROW_WIDTH(12)
  ) bus ();

  hammer_campaign_ctrl #(
    .ADDR_WIDTH(64), .WORD_WIDTH(64), .ROW_WIDTH(12),
    .ROW_POS(10), .LOG_DEPTH(4), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_address(base_address), .row_count(row_count),
    .hammer_count(hammer_count), .pattern(pattern), .bus(bus),
    .busy(busy), .done(done), .aborted(aborted),
    .timeout_err(timeout_err), .rows_done(rows_done),
    .total_flips(total_flips)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.eng_reset) eng_cyc <= 8'd0;
    else if (eng_cyc != 8'hFF) eng_cyc <= eng_cyc + 8'd1;
  end

  assign bus.eng_state = (!bus.eng_reset && !eng_hang && eng_cyc >= 8'd3)
                         ? 4'd4 : 4'd1;
  assign bus.eng_flips = flip_tab[bus.eng_address[10 +: 12]];

  always @(negedge clk) begin
    if (prev_rst === 1'b1 && bus.eng_reset === 1'b0)
      launch_q.push_back(bus.eng_address);
    prev_rst = bus.eng_reset;
  end

  function automatic logic [63:0] exp_addr(input logic [63:0] base,
                                           input int row);
    logic [63:0] m;
    m = 64'hFFF << 10;
    return (base & ~m) | (64'(row & 12'hFFF) << 10);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [63:0] base, input logic [11:0] n);
    @(negedge clk);
    launch_q.delete();
    base_address = base;
    row_count    = n;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_rows(input string tag, input logic [11:0] r,
                           input int max);
    int n = 0;
    while (rows_done !== r && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(rows_done), 64'(r));
  endtask

  task automatic pop_chk(input string tag, input logic [11:0] row,
                         input logic [31:0] fl);
    chk({tag, "_valid"}, 64'(bus.log_valid), 64'd1);
    chk({tag, "_row"}, 64'(bus.log_row), 64'(row));
    chk({tag, "_flips"}, 64'(bus.log_flips), 64'(fl));
    bus.log_ready = 1'b1;
    @(negedge clk);
    bus.log_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] b;
    int n;
    for (int i = 0; i < 4096; i++) flip_tab[i] = 64'd0;
    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    base_address  = '0;
    row_count     = '0;
    hammer_count  = 32'd1000;
    pattern       = 64'hDEAD_BEEF_0123_4567;
    eng_hang      = 1'b0;
    bus.log_ready = 1'b0;
    prev_rst      = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_eng_reset", 64'(bus.eng_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_log_valid", 64'(bus.log_valid), 64'd0);
    chk("rst_total", total_flips, 64'd0);
    chk("rst_addr", bus.eng_address, 64'd0);
    chk("rst_overflow", 64'(bus.log_overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // three rows, flips 0/5/2
    b = 64'hA5A5_0000_0000_0000 | (64'd100 << 10) | 64'h155;
    flip_tab[100] = 64'd0;
    flip_tab[101] = 64'd5;
    flip_tab[102] = 64'd2;
    go(b, 12'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done", 200);
    chk("t1_nlaunch", 64'(launch_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("t1_addr", launch_q[i], exp_addr(b, 100 + i));
    chk("t1_total", total_flips, 64'd7);
    chk("t1_rows", 64'(rows_done), 64'd3);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_count", 64'(bus.eng_count), 64'd1000);
    chk("t1_pattern", bus.eng_pattern, 64'hDEAD_BEEF_0123_4567);
    pop_chk("t1_e0", 12'd1, 32'd5);
    pop_chk("t1_e1", 12'd2, 32'd2);
    chk("t1_empty", 64'(bus.log_valid), 64'd0);

    // zero rows
    go(b, 12'd0);
    @(negedge clk);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_nlaunch", 64'(launch_q.size()), 64'd0);
    chk("t2_total", total_flips, 64'd0);
    chk("t2_rows", 64'(rows_done), 64'd0);

    // row field wrap
    b = 64'h1234_5678_0000_0000 | (64'd4095 << 10) | 64'h3FF;
    go(b, 12'd2);
    wait_done("t3_done", 200);
    chk("t3_nlaunch", 64'(launch_q.size()), 64'd2);
    chk("t3_addr0", launch_q[0], b);
    chk("t3_addr1", launch_q[1], 64'h1234_5678_0000_03FF);
    chk("t3_rows", 64'(rows_done), 64'd2);

    // watchdog: 100 RUN cycles per row
    eng_hang = 1'b1;
    b = 64'd200 << 10;
    go(b, 12'd2);
    n = 0;
    while (bus.eng_reset !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_run", 64'(bus.eng_reset), 64'd0);
    repeat (99) @(negedge clk);
    chk("t4_to_early", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("t4_to_set", 64'(timeout_err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    wait_done("t4_done", 400);
    chk("t4_nlaunch", 64'(launch_q.size()), 64'd2);
    chk("t4_rows", 64'(rows_done), 64'd2);
    chk("t4_total", total_flips, 64'd0);
    chk("t4_log", 64'(bus.log_valid), 64'd0);
    eng_hang = 1'b0;

    // 18 single-flip rows into a 16-deep log
    for (int i = 300; i < 318; i++) flip_tab[i] = 64'd1;
    b = 64'd300 << 10;
    go(b, 12'd18);
    chk("t5_to_clr", 64'(timeout_err), 64'd0);
    wait_done("t5_done", 400);
    chk("t5_total", total_flips, 64'd18);
    chk("t5_ovf", 64'(bus.log_overflow), 64'd1);
    chk("t5_rows", 64'(rows_done), 64'd18);
    for (int i = 0; i < 16; i++)
      pop_chk("t5_e", 12'(i), 32'd1);
    chk("t5_empty", 64'(bus.log_valid), 64'd0);

    // abort after three rows keeps partial results
    go(b, 12'd10);
    wait_rows("t6_rows3", 12'd3, 200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_aborted", 64'(aborted), 64'd1);
    chk("t6_eng_reset", 64'(bus.eng_reset), 64'd1);
    chk("t6_rows", 64'(rows_done), 64'd3);
    chk("t6_total", total_flips, 64'd3);
    chk("t6_ovf", 64'(bus.log_overflow), 64'd0);
    for (int i = 0; i < 3; i++)
      pop_chk("t6_e", 12'(i), 32'd1);
    chk("t6_empty", 64'(bus.log_valid), 64'd0);

    // 32-bit log saturation and 64-bit total saturation
    flip_tab[500] = 64'h1_0000_0000;
    flip_tab[501] = 64'hFFFF_FFFF_FFFF_FFF0;
    b = 64'd500 << 10;
    go(b, 12'd2);
    chk("t7_abort_clr", 64'(aborted), 64'd0);
    wait_done("t7_done", 200);
    chk("t7_total", total_flips, 64'hFFFF_FFFF_FFFF_FFFF);
    pop_chk("t7_e0", 12'd0, 32'hFFFF_FFFF);
    pop_chk("t7_e1", 12'd1, 32'hFFFF_FFFF);

    // asynchronous reset mid-campaign
    for (int i = 600; i < 605; i++) flip_tab[i] = 64'd1;
    b = 64'd600 << 10;
    go(b, 12'd5);
    wait_rows("t8_rows2", 12'd2, 200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_done", 64'(done), 64'd0);
    chk("t8_rows", 64'(rows_done), 64'd0);
    chk("t8_total", total_flips, 64'd0);
    chk("t8_log", 64'(bus.log_valid), 64'd0);
    chk("t8_eng_reset", 64'(bus.eng_reset), 64'd1);
    chk("t8_addr", bus.eng_address, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
